// File: rtl/serial_scrambler.sv
// serial_scrambler: additive x^7+x^4+1 LFSR scrambler that serialises accepted
// bytes LSB first, one bit per rising edge of the divided bit clock. The bit
// clock is sampled on clk and edge-detected; nothing here runs on bit_clk.
module serial_scrambler #(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 7,
  parameter int                TAP_A  = 6,
  parameter int                TAP_B  = 3,
  parameter logic [LFSR_W-1:0] SEED   = 7'h7F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_clk,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              seed_load,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_sop
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]        state_q,     state_d;
  logic [LFSR_W-1:0] lfsr_q,      lfsr_d;
  logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [DATA_W-1:0] shreg_q,     shreg_d;
  logic              bit_clk_q;
  logic              ser_out_q,   ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              frame_sop_q, frame_sop_d;
  logic              seed_pend_q, seed_pend_d;

  logic tick;
  logic shift_tick;
  logic last_tick;
  logic fb;
  logic accept;

  assign tick       = bit_clk & ~bit_clk_q;
  assign shift_tick = (state_q == S_SHIFT) & tick;
  assign last_tick  = shift_tick & (bit_cnt_q == LAST_BIT);
  assign fb         = lfsr_q[TAP_A] ^ lfsr_q[TAP_B];
  // Ready in IDLE, and for the single last-bit tick cycle so bytes run gapless.
  assign in_ready   = (state_q == S_IDLE) | last_tick;
  assign accept     = in_valid & in_ready;

  // Next-state logic: byte acceptance, per-tick scrambling and deferred reseed.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = 1'b0;
    frame_sop_d = 1'b0;
    seed_pend_d = seed_pend_q;

    case (state_q)
      S_IDLE: begin
        // Nothing in flight, so a reseed takes effect at once and also
        // covers a byte accepted in this same cycle.
        seed_pend_d = 1'b0;
        if (seed_load) begin
          lfsr_d = SEED;
        end
        if (accept) begin
          shreg_d   = in_data;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // A reseed mid-byte is parked until the byte boundary.
        if (seed_load) begin
          seed_pend_d = 1'b1;
        end
        if (shift_tick) begin
          ser_out_d   = shreg_q[bit_cnt_q] ^ fb;
          lfsr_d      = {lfsr_q[LFSR_W-2:0], fb};
          ser_valid_d = 1'b1;
          frame_sop_d = (bit_cnt_q == '0);
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        end
        if (last_tick) begin
          bit_cnt_d = '0;
          if (seed_pend_q | seed_load) begin
            lfsr_d      = SEED;
            seed_pend_d = 1'b0;
          end
          if (accept) begin
            shreg_d = in_data;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; async reset returns every register to its idle value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      bit_clk_q   <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      frame_sop_q <= 1'b0;
      seed_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      bit_clk_q   <= bit_clk;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      frame_sop_q <= frame_sop_d;
      seed_pend_q <= seed_pend_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign frame_sop = frame_sop_q;

endmodule

// File: tb/tb_serial_scrambler.sv
// Directed bench for serial_scrambler with a /8 bit clock generator.
module tb_serial_scrambler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_clk = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       seed_load = 1'b0;
  logic       ser_out;
  logic       ser_valid;
  logic       frame_sop;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit bclk_run = 1'b0;
  logic [2:0] div = 3'd0;

  bit bit_q[$];
  bit sop_q[$];
  int cyc_q[$];

  serial_scrambler dut (
    .clk(clk), .rst_n(rst_n), .bit_clk(bit_clk),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .seed_load(seed_load), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_sop(frame_sop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // /8 divider, synchronous to clk, can be frozen
  always @(posedge clk) begin
    if (bclk_run) begin
      div <= div + 3'd1;
      bit_clk <= div[2];
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && ser_valid) begin
      bit_q.push_back(ser_out);
      sop_q.push_back(frame_sop);
      cyc_q.push_back(cyc);
    end
  end

  task automatic clear_q();
    bit_q.delete(); sop_q.delete(); cyc_q.delete();
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_bits(input int n, output bit to);
    to = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (bit_q.size() >= n) begin to = 1'b0; break; end
      step();
    end
    if (bit_q.size() >= n) to = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b, output bit ok);
    bit acc;
    ok = 1'b0;
    in_data = b; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      acc = in_ready;
      step();
      if (acc) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_seed();
    seed_load = 1'b1; step(); seed_load = 1'b0;
  endtask

  function automatic logic [15:0] pack_bits(input int n, input bit sel_sop);
    logic [15:0] v = '0;
    for (int i = 0; i < n && i < 16; i++) v[i] = sel_sop ? sop_q[i] : bit_q[i];
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom); in_data = 8'($urandom);
      seed_load = 1'($urandom); bit_clk = 1'($urandom);
      step();
      n_cmp++;
      if ({ser_out, ser_valid, frame_sop} !== 3'b000) begin
        n_bad++; $display("FAIL reset_outs: got %b expected 000", {ser_out, ser_valid, frame_sop});
      end
    end
    in_valid = 1'b0; seed_load = 1'b0; bit_clk = 1'b0;
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    n_cmp++;
    if (dut.lfsr_q !== 7'h7F) begin n_bad++; $display("FAIL reset_lfsr: got %h expected 7f", dut.lfsr_q); end
  endtask

  task automatic test_single_byte();
    bit ok, to;
    logic [15:0] v;
    clear_q();
    bclk_run = 1'b1;
    put_byte(8'h00, ok);
    wait_bits(8, to);
    n_cmp++;
    if (!ok || to) begin n_bad++; $display("FAIL t2_timeout: got ok=%0d to=%0d expected ok=1 to=0", ok, to); end
    n_cmp++;
    if (dut.lfsr_q !== 7'h0E) begin n_bad++; $display("FAIL t2_lfsr: got %h expected 0e", dut.lfsr_q); end
    v = pack_bits(8, 1'b0);
    n_cmp++;
    if (v[7:0] !== 8'h70) begin n_bad++; $display("FAIL t2_bits: got %h expected 70", v[7:0]); end
    v = pack_bits(8, 1'b1);
    n_cmp++;
    if (v[7:0] !== 8'h01) begin n_bad++; $display("FAIL t2_sop: got %h expected 01", v[7:0]); end
    for (int i = 1; i < 8 && i < cyc_q.size(); i++) begin
      n_cmp++;
      if (cyc_q[i] - cyc_q[i-1] !== 8) begin
        n_bad++; $display("FAIL t2_spacing%0d: got %0d expected 8", i, cyc_q[i] - cyc_q[i-1]);
      end
    end
    repeat (20) step();
    n_cmp++;
    if (bit_q.size() !== 8) begin n_bad++; $display("FAIL t2_count: got %0d expected 8", bit_q.size()); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL t2_idle: got %b expected 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int nrdy = 0;
    int stage = 0;
    bit to, acc;
    logic [15:0] v;
    pulse_seed();
    clear_q();
    in_data = 8'h00; in_valid = 1'b1;
    for (int i = 0; i < 300 && stage < 2; i++) begin
      acc = in_ready;
      if (acc) nrdy++;
      step();
      if (acc) begin
        stage++;
        in_data = 8'hFF;
      end
    end
    in_valid = 1'b0;
    wait_bits(16, to);
    repeat (3) step();
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL t3_timeout: got %0d bits expected 16", bit_q.size()); end
    n_cmp++;
    if (nrdy !== 2) begin n_bad++; $display("FAIL t3_ready_count: got %0d expected 2", nrdy); end
    v = pack_bits(16, 1'b0);
    n_cmp++;
    if (v !== 16'hB070) begin n_bad++; $display("FAIL t3_bits: got %h expected b070", v); end
    v = pack_bits(16, 1'b1);
    n_cmp++;
    if (v !== 16'h0101) begin n_bad++; $display("FAIL t3_sop: got %h expected 0101", v); end
    n_cmp++;
    if (cyc_q.size() < 16 || cyc_q[15] - cyc_q[0] !== 120) begin
      n_bad++; $display("FAIL t3_gapless: got span %0d expected 120", cyc_q.size() >= 16 ? cyc_q[15] - cyc_q[0] : -1);
    end
    n_cmp++;
    if (dut.lfsr_q !== 7'h72) begin n_bad++; $display("FAIL t3_lfsr: got %h expected 72", dut.lfsr_q); end
  endtask

  task automatic test_frozen_clock();
    bit to;
    logic [15:0] v;
    bclk_run = 1'b0;
    pulse_seed();
    clear_q();
    in_data = 8'h00; in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL t4_ready_idle: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL t4_ready_busy: got %b expected 0", in_ready); end
    repeat (30) step();
    n_cmp++;
    if (bit_q.size() !== 0) begin n_bad++; $display("FAIL t4_frozen: got %0d pulses expected 0", bit_q.size()); end
    bclk_run = 1'b1;
    wait_bits(8, to);
    v = pack_bits(8, 1'b0);
    n_cmp++;
    if (to || v[7:0] !== 8'h70) begin n_bad++; $display("FAIL t4_bits: got %h expected 70", v[7:0]); end
  endtask

  task automatic test_seed_mid_byte();
    bit ok, to;
    logic [15:0] v;
    pulse_seed();
    clear_q();
    put_byte(8'h00, ok);
    wait_bits(3, to);
    pulse_seed();
    wait_bits(8, to);
    v = pack_bits(8, 1'b0);
    n_cmp++;
    if (!ok || to || v[7:0] !== 8'h70) begin n_bad++; $display("FAIL t5_bits: got %h expected 70", v[7:0]); end
    n_cmp++;
    if (dut.lfsr_q !== 7'h7F) begin n_bad++; $display("FAIL t5_lfsr: got %h expected 7f", dut.lfsr_q); end
    repeat (4) step();
    clear_q();
    put_byte(8'h00, ok);
    wait_bits(8, to);
    v = pack_bits(8, 1'b0);
    n_cmp++;
    if (!ok || to || v[7:0] !== 8'h70) begin n_bad++; $display("FAIL t5_next: got %h expected 70", v[7:0]); end
  endtask

  task automatic test_reset_mid_byte();
    bit ok, to;
    logic [15:0] v;
    pulse_seed();
    clear_q();
    put_byte(8'h00, ok);
    wait_bits(5, to);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ser_out, ser_valid, frame_sop} !== 3'b000) begin
      n_bad++; $display("FAIL t6_async: got %b expected 000", {ser_out, ser_valid, frame_sop});
    end
    repeat (3) step();
    rst_n = 1'b1;
    clear_q();
    repeat (30) step();
    n_cmp++;
    if (bit_q.size() !== 0) begin n_bad++; $display("FAIL t6_quiet: got %0d pulses expected 0", bit_q.size()); end
    put_byte(8'h00, ok);
    wait_bits(8, to);
    v = pack_bits(8, 1'b0);
    n_cmp++;
    if (!ok || to || v[7:0] !== 8'h70) begin n_bad++; $display("FAIL t6_bits: got %h expected 70", v[7:0]); end
  endtask

  initial begin
    step();
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frozen_clock();
    test_seed_mid_byte();
    test_reset_mid_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
